matrix_stream_arbiter: RTL and testbench

- Round-robin arbiter that shares one downstream matrix consumer (matrix FIFO or matmul input port) between NUM_REQ matrix producers.
- Arbitration is matrix-granular with burst locking: a granted requester keeps the port for up to BURST_LEN matrices, or until it flags last.
- The output is a single registered valid/ready stage carrying the matrix, the source ID and a last flag.

---
 rtl/matrix_stream_arbiter.sv | 160 ++++++++++++++++
 tb/tb_matrix_stream_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_stream_arbiter.sv
// Round-robin, burst-locking arbiter sharing one registered matrix valid/ready port among NUM_REQ producers.
// Define MATRIX_ARB_STATS_EN to build the per-requester saturating accepted-matrix counters.
module matrix_stream_arbiter #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DIM0       = 4,
  parameter int unsigned DIM1       = 4,
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned BURST_LEN  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DATA_WIDTH-1:0]        in_data [NUM_REQ*DIM0*DIM1],
  input  logic [NUM_REQ-1:0]           in_valid,
  input  logic [NUM_REQ-1:0]           in_last,
  output logic [NUM_REQ-1:0]           in_ready,
  output logic [DATA_WIDTH-1:0]        out_data [DIM0*DIM1],
  output logic [$clog2(NUM_REQ)-1:0]   out_id,
  output logic                         out_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [15:0]                  grant_count [NUM_REQ]
);

  localparam int unsigned MSZ = DIM0 * DIM1;
  localparam int unsigned IDW = $clog2(NUM_REQ);
  localparam int unsigned BCW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                state_q, state_d;
  logic [IDW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]        grant_id_q, grant_id_d;
  logic [BCW-1:0]        beat_cnt_q, beat_cnt_d;
  logic                  out_valid_q;
  logic                  out_last_q;
  logic [IDW-1:0]        out_id_q;
  logic [DATA_WIDTH-1:0] out_data_q [MSZ];
  logic [DATA_WIDTH-1:0] sel_data [MSZ];

  logic                  pick_vld;
  logic [IDW-1:0]        pick_id;
  logic [IDW-1:0]        cand;
  logic                  slot_free;
  logic                  accept;
  logic                  last_beat;

  // First valid requester scanning from rr_ptr upward, wrapping at NUM_REQ.
  always_comb begin
    pick_vld = 1'b0;
    pick_id  = '0;
    cand     = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = IDW'((32'(rr_ptr_q) + i) % NUM_REQ);
      if (!pick_vld && in_valid[cand]) begin
        pick_vld = 1'b1;
        pick_id  = cand;
      end
    end
  end

  always_comb begin
    for (int unsigned j = 0; j < MSZ; j++) sel_data[j] = '0;
    for (int unsigned r = 0; r < NUM_REQ; r++) begin
      if (grant_id_q == IDW'(r)) begin
        for (int unsigned j = 0; j < MSZ; j++) sel_data[j] = in_data[r*MSZ + j];
      end
    end
  end

  assign slot_free = ~out_valid_q | out_ready;
  assign accept    = (state_q == BUSY) & in_valid[grant_id_q] & slot_free;
  assign last_beat = in_last[grant_id_q] | (beat_cnt_q == BCW'(BURST_LEN - 1));

  always_comb begin
    in_ready = '0;
    if (state_q == BUSY) in_ready[grant_id_q] = slot_free;
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          grant_id_d = pick_id;
          beat_cnt_d = '0;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        if (accept) begin
          if (last_beat) begin
            state_d  = IDLE;
            rr_ptr_d = (grant_id_q == IDW'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // Load on accept takes priority over drain so a concurrent drain+refill keeps out_valid high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_id_q    <= '0;
      out_data_q  <= '{default: '0};
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_last_q  <= last_beat;
      out_id_q    <= grant_id_q;
      out_data_q  <= sel_data;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_id    = out_id_q;
  assign out_data  = out_data_q;

`ifdef MATRIX_ARB_STATS_EN
  logic [15:0] cnt_q [NUM_REQ];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '{default: '0};
    end else begin
      for (int unsigned r = 0; r < NUM_REQ; r++) begin
        if (accept && (grant_id_q == IDW'(r)) && (cnt_q[r] != 16'hFFFF)) cnt_q[r] <= cnt_q[r] + 16'd1;
      end
    end
  end

  assign grant_count = cnt_q;
`else
  assign grant_count = '{default: '0};
`endif

endmodule

// File: tb/tb_matrix_stream_arbiter.sv
// Directed self-checking bench for matrix_stream_arbiter: default 4x4 build plus a NUM_REQ=3, BURST_LEN=1 instance.
module tb_matrix_stream_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data [64];
  logic [3:0] in_valid, in_last, in_ready;
  logic [7:0] out_data [16];
  logic [1:0] out_id;
  logic       out_last, out_valid, out_ready;
  logic [15:0] grant_count [4];

  logic [7:0] b_in_data [48];
  logic [2:0] b_in_valid, b_in_last, b_in_ready;
  logic [7:0] b_out_data [16];
  logic [1:0] b_out_id;
  logic       b_out_last, b_out_valid, b_out_ready;
  logic [15:0] b_grant_count [3];

  int vectors = 0;
  int errors  = 0;

  logic [19:0] obs, b_obs;
  assign obs   = {out_valid, out_id, out_last, out_data[0], out_data[15]};
  assign b_obs = {b_out_valid, b_out_id, b_out_last, b_out_data[0], b_out_data[15]};

  always #5 clk = ~clk;

  matrix_stream_arbiter #(.DATA_WIDTH(8), .DIM0(4), .DIM1(4), .NUM_REQ(4), .BURST_LEN(4)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .out_data(out_data), .out_id(out_id), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready), .grant_count(grant_count));

  matrix_stream_arbiter #(.DATA_WIDTH(8), .DIM0(4), .DIM1(4), .NUM_REQ(3), .BURST_LEN(1)) dut_b1 (
    .clk(clk), .rst(rst), .in_data(b_in_data), .in_valid(b_in_valid), .in_last(b_in_last),
    .in_ready(b_in_ready), .out_data(b_out_data), .out_id(b_out_id), .out_last(b_out_last),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .grant_count(b_grant_count));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Element j of requester r's matrix carries v + j.
  task automatic set_mat(input int r, input logic [7:0] v);
    for (int j = 0; j < 16; j++) in_data[r*16 + j] = v + 8'(j);
  endtask

  task automatic set_mat_b(input int r, input logic [7:0] v);
    for (int j = 0; j < 16; j++) b_in_data[r*16 + j] = v + 8'(j);
  endtask

  task automatic do_reset;
    in_valid = '0; in_last = '0; out_ready = 1'b1;
    b_in_valid = '0; b_in_last = '0; b_out_ready = 1'b1;
    rst = 1'b0;
    tick;
    tick;
    rst = 1'b1;
  endtask

  task automatic test_reset;
    logic [7:0]  dor;
    logic [15:0] gor;
    for (int r = 0; r < 4; r++) set_mat(r, 8'(r * 16 + 1));
    for (int r = 0; r < 3; r++) set_mat_b(r, 8'h01);
    in_valid = '0; in_last = '0; out_ready = 1'b1;
    b_in_valid = '0; b_in_last = '0; b_out_ready = 1'b1;
    rst = 1'b0;
    #1;
    dor = '0; gor = '0;
    for (int j = 0; j < 16; j++) dor |= out_data[j];
    for (int r = 0; r < 4; r++) gor |= grant_count[r];
    vectors++;
    if ({obs, in_ready, dor, gor} !== '0) begin
      errors++;
      $display("FAIL reset_state: obs=%h in_ready=%b data_or=%h gc_or=%h, want all 0", obs, in_ready, dor, gor);
    end
    tick;
    tick;
    rst = 1'b1;
  endtask

  task automatic test_single;
    do_reset;
    set_mat(2, 8'h11);
    in_valid = 4'b0100;
    vectors++;
    if (in_ready !== 4'b0000) begin errors++; $display("FAIL single_idle_ready: got %b want 0000", in_ready); end
    tick;
    vectors++;
    if ({in_ready, out_valid} !== 5'b0100_0) begin
      errors++; $display("FAIL single_grant: in_ready,out_valid=%b want 01000", {in_ready, out_valid});
    end
    tick;
    vectors++;
    if (obs !== {1'b1, 2'd2, 1'b0, 8'h11, 8'h20} || in_ready !== 4'b0100) begin
      errors++; $display("FAIL single_beat0: obs=%h in_ready=%b want %h 0100", obs, in_ready, {1'b1, 2'd2, 1'b0, 8'h11, 8'h20});
    end
    set_mat(2, 8'h22);
    in_last[2] = 1'b1;
    tick;
    vectors++;
    if (obs !== {1'b1, 2'd2, 1'b1, 8'h22, 8'h31} || in_ready !== 4'b0000) begin
      errors++; $display("FAIL single_beat1: obs=%h in_ready=%b want %h 0000", obs, in_ready, {1'b1, 2'd2, 1'b1, 8'h22, 8'h31});
    end
    in_valid = '0; in_last = '0;
    tick;
    vectors++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL single_drain: out_valid=%b want 0", out_valid); end
    // rr_ptr should now be 3, so r3 beats r0.
    set_mat(3, 8'h33);
    in_valid = 4'b1001;
    tick;
    vectors++;
    if (in_ready !== 4'b1000) begin errors++; $display("FAIL single_rrptr3: in_ready=%b want 1000", in_ready); end
    in_last[3] = 1'b1;
    tick;
    vectors++;
    if (obs !== {1'b1, 2'd3, 1'b1, 8'h33, 8'h42}) begin
      errors++; $display("FAIL single_r3: obs=%h want %h", obs, {1'b1, 2'd3, 1'b1, 8'h33, 8'h42});
    end
    in_valid = '0; in_last = '0;
    tick;
  endtask

  task automatic test_fairness;
    logic [19:0] exp;
    logic [7:0]  base;
    int p;
    bit hi;
    do_reset;
    set_mat(0, 8'hA0);
    set_mat(3, 8'hD0);
    in_valid = 4'b1001;
    tick;
    for (int k = 0; k < 14; k++) begin
      tick;
      p  = k % 5;
      hi = ((k / 5) % 2) == 1;
      base = hi ? 8'hD0 : 8'hA0;
      exp = {1'b1, (hi ? 2'd3 : 2'd0), (p == 3), base, base + 8'd15};
      vectors++;
      if (p == 4) begin
        if (out_valid !== 1'b0) begin errors++; $display("FAIL fair_bubble k=%0d: out_valid=%b want 0", k, out_valid); end
      end else if (obs !== exp) begin
        errors++; $display("FAIL fair_seq k=%0d: obs=%h want %h", k, obs, exp);
      end
    end
    in_valid = '0;
  endtask

  task automatic test_backpressure;
    do_reset;
    out_ready = 1'b0;
    set_mat(1, 8'h51);
    in_valid = 4'b0010;
    tick;
    vectors++;
    if (in_ready !== 4'b0010) begin errors++; $display("FAIL bp_grant: in_ready=%b want 0010", in_ready); end
    tick;
    set_mat(1, 8'h52);
    for (int c = 0; c < 5; c++) begin
      vectors++;
      if (obs !== {1'b1, 2'd1, 1'b0, 8'h51, 8'h60} || in_ready !== 4'b0000) begin
        errors++; $display("FAIL bp_hold c=%0d: obs=%h in_ready=%b want %h 0000", c, obs, in_ready, {1'b1, 2'd1, 1'b0, 8'h51, 8'h60});
      end
      if (c < 4) tick;
    end
    out_ready = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 4'b0010) begin errors++; $display("FAIL bp_release_ready: in_ready=%b want 0010", in_ready); end
    tick;
    vectors++;
    if (obs !== {1'b1, 2'd1, 1'b0, 8'h52, 8'h61}) begin
      errors++; $display("FAIL bp_refill: obs=%h want %h", obs, {1'b1, 2'd1, 1'b0, 8'h52, 8'h61});
    end
    set_mat(1, 8'h53);
    tick;
    vectors++;
    if (obs !== {1'b1, 2'd1, 1'b0, 8'h53, 8'h62}) begin
      errors++; $display("FAIL bp_stream: obs=%h want %h", obs, {1'b1, 2'd1, 1'b0, 8'h53, 8'h62});
    end
    // in_last coincides with the BURST_LEN limit here.
    set_mat(1, 8'h54);
    in_last[1] = 1'b1;
    tick;
    vectors++;
    if (obs !== {1'b1, 2'd1, 1'b1, 8'h54, 8'h63} || in_ready !== 4'b0000) begin
      errors++; $display("FAIL bp_last: obs=%h in_ready=%b want %h 0000", obs, in_ready, {1'b1, 2'd1, 1'b1, 8'h54, 8'h63});
    end
    in_valid = '0; in_last = '0;
    tick;
    vectors++;
    if ({out_valid, in_ready} !== 5'b0) begin
      errors++; $display("FAIL bp_end: out_valid,in_ready=%b want 00000", {out_valid, in_ready});
    end
  endtask

  task automatic test_grant_hold;
    do_reset;
    set_mat(1, 8'h61);
    set_mat(0, 8'h01);
    in_valid = 4'b0010;
    tick;
    tick;
    in_valid = 4'b0001;
    for (int c = 0; c < 3; c++) begin
      tick;
      vectors++;
      if (in_ready !== 4'b0010) begin errors++; $display("FAIL hold_ready c=%0d: in_ready=%b want 0010", c, in_ready); end
    end
    set_mat(1, 8'h62);
    in_valid = 4'b0011;
    in_last[1] = 1'b1;
    tick;
    vectors++;
    if (obs !== {1'b1, 2'd1, 1'b1, 8'h62, 8'h71}) begin
      errors++; $display("FAIL hold_last: obs=%h want %h", obs, {1'b1, 2'd1, 1'b1, 8'h62, 8'h71});
    end
    in_last = '0;
    tick;
    vectors++;
    if (in_ready !== 4'b0001) begin errors++; $display("FAIL hold_next_grant: in_ready=%b want 0001", in_ready); end
    in_valid = '0;
  endtask

  task automatic test_reset_midburst;
    do_reset;
    set_mat(2, 8'h71);
    set_mat(0, 8'h81);
    in_valid = 4'b0100;
    tick;
    tick;
    tick;
    rst = 1'b0;
    #1;
    vectors++;
    if (obs !== '0 || in_ready !== 4'b0000) begin
      errors++; $display("FAIL midburst_reset: obs=%h in_ready=%b want 0 0000", obs, in_ready);
    end
    in_valid = 4'b0101;
    tick;
    rst = 1'b1;
    tick;
    vectors++;
    if (in_ready !== 4'b0001) begin errors++; $display("FAIL midburst_regrant: in_ready=%b want 0001", in_ready); end
    in_valid = '0;
  endtask

  task automatic test_burst1;
    logic [19:0] exp;
    int id;
    do_reset;
    set_mat_b(0, 8'h10);
    set_mat_b(1, 8'h20);
    set_mat_b(2, 8'h30);
    b_in_valid = 3'b111;
    tick;
    for (int k = 0; k < 8; k++) begin
      tick;
      id  = (k / 2) % 3;
      exp = {1'b1, 2'(id), 1'b1, 8'(16 * (id + 1)), 8'(16 * (id + 1) + 15)};
      vectors++;
      if (k % 2 == 1) begin
        if (b_out_valid !== 1'b0) begin errors++; $display("FAIL b1_bubble k=%0d: out_valid=%b want 0", k, b_out_valid); end
      end else if (b_obs !== exp) begin
        errors++; $display("FAIL b1_seq k=%0d: obs=%h want %h", k, b_obs, exp);
      end
    end
    b_in_valid = '0;
  endtask

  task automatic send(input int r, input int n);
    int sent, guard;
    bit acc;
    sent = 0; guard = 0;
    in_valid[r] = 1'b1;
    while (sent < n && guard < 100) begin
      in_last[r] = (sent == n - 1);
      acc = in_ready[r];
      tick;
      if (acc) sent++;
      guard++;
    end
    in_valid[r] = 1'b0;
    in_last[r]  = 1'b0;
    vectors++;
    if (sent != n) begin errors++; $display("FAIL send_timeout r=%0d: sent=%0d want %0d", r, sent, n); end
    tick;
    tick;
  endtask

  task automatic test_stats;
    logic [15:0] e0, e1;
`ifdef MATRIX_ARB_STATS_EN
    e0 = 16'd3; e1 = 16'd5;
`else
    e0 = 16'd0; e1 = 16'd0;
`endif
    do_reset;
    set_mat(0, 8'h05);
    set_mat(1, 8'h06);
    send(0, 3);
    vectors++;
    if (grant_count[0] !== e0 || grant_count[1] !== 16'd0) begin
      errors++; $display("FAIL stats_r0: gc0=%0d gc1=%0d want %0d 0", grant_count[0], grant_count[1], e0);
    end
    send(1, 5);
    vectors++;
    if ({grant_count[0], grant_count[1], grant_count[2], grant_count[3]} !== {e0, e1, 16'd0, 16'd0}) begin
      errors++; $display("FAIL stats_all: gc=%0d,%0d,%0d,%0d want %0d,%0d,0,0",
                         grant_count[0], grant_count[1], grant_count[2], grant_count[3], e0, e1);
    end
  endtask

  initial begin
    rst = 1'b0;
    test_reset;
    test_single;
    test_fairness;
    test_backpressure;
    test_grant_hold;
    test_reset_midburst;
    test_burst1;
    test_stats;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
